// File: rtl/bkm_drv_pkg.sv
// Shared types for the bkm_steps stimulus sequencer: FSM states, tag bundle,
// FIFO pointer sizing helper.
package bkm_drv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } drv_state_e;

  localparam int FIFO_DEPTH_DEF = 4;

  // Pointer width for a power-of-two FIFO of the given depth
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_PTR_W = ptr_w(FIFO_DEPTH_DEF);

  typedef struct packed {
    logic       mode;
    logic [1:0] format;
  } drv_tag_t;

endpackage

// File: rtl/bkm_steps_stim_seq_if.sv
// Operand-set stream into the sequencer and issued-set bus out of it.
// slave = the sequencer, master = whoever feeds it and consumes its output.
interface bkm_steps_stim_seq_if #(
  parameter int WD = 72,
  parameter int WC = 21
);
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [1:0]    in_format;
  logic [WD-1:0] in_X;
  logic [WD-1:0] in_Y;
  logic [WC-1:0] in_u;
  logic [WC-1:0] in_v;

  logic            out_valid;
  logic            out_mode;
  logic [1:0]      out_format;
  logic [2*WD-1:0] X_in_csd;
  logic [2*WD-1:0] Y_in_csd;
  logic [WC-1:0]   u_in_bin;
  logic [WC-1:0]   v_in_bin;

  modport slave (
    input  in_valid, in_mode, in_format, in_X, in_Y, in_u, in_v,
    output in_ready,
    output out_valid, out_mode, out_format, X_in_csd, Y_in_csd, u_in_bin, v_in_bin
  );

  modport master (
    output in_valid, in_mode, in_format, in_X, in_Y, in_u, in_v,
    input  in_ready,
    input  out_valid, out_mode, out_format, X_in_csd, Y_in_csd, u_in_bin, v_in_bin
  );
endinterface

// File: rtl/bin2csd.sv
// Two's complement to canonical signed digit (non-adjacent form).
// Digit i lives in csd_o[2i+1:2i] as {neg, pos}: 01 = +1, 10 = -1, 00 = 0.
// Digit i is bit i+1 of 3x minus bit i+1 of x; bit 0 of 3x equals x[0], so the
// sum only needs bits W:1, computed from the sign-extended operand.
module bin2csd #(
  parameter int W = 72
) (
  input  logic [W-1:0]   bin_i,
  output logic [2*W-1:0] csd_o
);
  logic [W:0]   xs;
  logic [W-1:0] x3_hi;
  logic [W-1:0] pos;
  logic [W-1:0] neg;

  assign xs    = {bin_i[W-1], bin_i};
  assign x3_hi = xs[W:1] + xs[W-1:0];
  assign pos   = x3_hi & ~xs[W:1];
  assign neg   = ~x3_hi & xs[W:1];

  // Interleave the positive/negative digit planes
  always_comb begin
    csd_o = '0;
    for (int i = 0; i < W; i++) begin
      csd_o[2*i]   = pos[i];
      csd_o[2*i+1] = neg[i];
    end
  end
endmodule

// File: rtl/bkm_drv_fifo.sv
// Synchronous FIFO with registered occupancy; head is read combinationally.
// Push is ignored while full, pop is ignored while empty.
module bkm_drv_fifo
  import bkm_drv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = ptr_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers and occupancy; reset flushes and drops a same-cycle push
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage array, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/bkm_steps_stim_seq.sv
// Buffered, back-pressured stimulus source for the bkm_steps datapath.
// Operand sets are queued, then issued at a cadence of gap+1 cycles with X/Y
// converted to CSD on the way into the output register.
// Optional macro BKM_DRV_SWEEP_EN: src_sel=1 issues from internal sweep
// counters instead of the FIFO.
module bkm_steps_stim_seq
  import bkm_drv_pkg::*;
#(
  parameter int WD    = 72,
  parameter int WC    = 21,
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   enable,
  input  logic [GAP_W-1:0]       gap,
  input  logic                   src_sel,
  bkm_steps_stim_seq_if.slave    bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            issue_cnt
);
  typedef struct packed {
    drv_tag_t      tag;
    logic [WD-1:0] x;
    logic [WD-1:0] y;
    logic [WC-1:0] u;
    logic [WC-1:0] v;
  } opset_t;

  opset_t          push_set;
  opset_t          head_set;
  opset_t          src_set;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            has_data;
  logic            issue;
  drv_state_e      state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [2*WD-1:0] x_csd, y_csd;

  logic            out_valid_q, out_mode_q;
  logic [1:0]      out_format_q;
  logic [2*WD-1:0] x_csd_q, y_csd_q;
  logic [WC-1:0]   u_q, v_q;
  logic [15:0]     issue_cnt_q;

  assign push_set = '{tag: '{mode: bus.in_mode, format: bus.in_format},
                      x: bus.in_X, y: bus.in_Y, u: bus.in_u, v: bus.in_v};

  bkm_drv_fifo #(.DEPTH(DEPTH), .W($bits(opset_t))) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (bus.in_valid),
    .pop_i   (fifo_pop),
    .din_i   (push_set),
    .dout_o  (head_set),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bus.in_ready = ~fifo_full;
  assign issue        = (state_q == IDLE) & enable & has_data;

`ifdef BKM_DRV_SWEEP_EN
  logic [WD-1:0] sw_x_q, sw_y_q;
  logic [WC-1:0] sw_u_q, sw_v_q;

  assign has_data = src_sel | ~fifo_empty;
  assign fifo_pop = issue & ~src_sel;

  // Source mux: sweep counters carry live tags, FIFO head carries stored ones
  always_comb begin
    src_set = head_set;
    if (src_sel) begin
      src_set = '{tag: '{mode: bus.in_mode, format: bus.in_format},
                  x: sw_x_q, y: sw_y_q, u: sw_u_q, v: sw_v_q};
    end
  end

  // Sweep counters step one LSB per sweep issue, wrapping at their width
  always_ff @(posedge clk) begin
    if (srst) begin
      sw_x_q <= '0;
      sw_y_q <= '0;
      sw_u_q <= '0;
      sw_v_q <= '0;
    end else if (issue && src_sel) begin
      sw_x_q <= sw_x_q + 1'b1;
      sw_y_q <= sw_y_q + 1'b1;
      sw_u_q <= sw_u_q + 1'b1;
      sw_v_q <= sw_v_q + 1'b1;
    end
  end
`else
  logic unused_src_sel;

  assign unused_src_sel = src_sel;
  assign has_data       = ~fifo_empty;
  assign fifo_pop       = issue;
  assign src_set        = head_set;
`endif

  bin2csd #(.W(WD)) u_csd_x (.bin_i(src_set.x), .csd_o(x_csd));
  bin2csd #(.W(WD)) u_csd_y (.bin_i(src_set.y), .csd_o(y_csd));

  // State and gap counter registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next state: issue from IDLE loads the gap; GAP counts down while enabled
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          gap_cnt_d = gap;
          state_d   = (gap != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (enable) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
          if (gap_cnt_q == GAP_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: strobe each issue, hold data between strobes
  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      out_format_q <= '0;
      x_csd_q      <= '0;
      y_csd_q      <= '0;
      u_q          <= '0;
      v_q          <= '0;
      issue_cnt_q  <= '0;
    end else begin
      out_valid_q <= issue;
      if (issue) begin
        out_mode_q   <= src_set.tag.mode;
        out_format_q <= src_set.tag.format;
        x_csd_q      <= x_csd;
        y_csd_q      <= y_csd;
        u_q          <= src_set.u;
        v_q          <= src_set.v;
        issue_cnt_q  <= issue_cnt_q + 16'd1;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_mode   = out_mode_q;
  assign bus.out_format = out_format_q;
  assign bus.X_in_csd   = x_csd_q;
  assign bus.Y_in_csd   = y_csd_q;
  assign bus.u_in_bin   = u_q;
  assign bus.v_in_bin   = v_q;
  assign issue_cnt      = issue_cnt_q;
endmodule

// File: tb/tb_bkm_steps_stim_seq.sv
// Bench for bkm_steps_stim_seq: directed scenarios with random operands,
// checked every cycle against a queue-based cycle model of the sequencer.
// Sweep scenario is compiled in when BKM_DRV_SWEEP_EN is defined.
module tb_bkm_steps_stim_seq;
  localparam int WD    = 72;
  localparam int WC    = 21;
  localparam int DEPTH = 4;
  localparam int GAP_W = 4;
  localparam int CW    = 2*WD;

  logic                   clk = 1'b0;
  logic                   srst;
  logic                   enable;
  logic [GAP_W-1:0]       gap;
  logic                   src_sel;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0]            issue_cnt;

  bkm_steps_stim_seq_if #(.WD(WD), .WC(WC)) bus ();

  bkm_steps_stim_seq #(.WD(WD), .WC(WC), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .srst       (srst),
    .enable     (enable),
    .gap        (gap),
    .src_sel    (src_sel),
    .bus        (bus),
    .fifo_level (fifo_level),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          mode;
    logic [1:0]    fmt;
    logic [WD-1:0] x;
    logic [WD-1:0] y;
    logic [WC-1:0] u;
    logic [WC-1:0] v;
  } set_t;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   strobes[$];
  set_t q[$];
  int   rem;
  logic [15:0] m_cnt;
  logic e_valid;
  set_t e_last;
  logic last_acc;
`ifdef BKM_DRV_SWEEP_EN
  logic [WD-1:0] sw_x, sw_y;
  logic [WC-1:0] sw_u, sw_v;
`endif

  // Non-adjacent form by repeated division: odd remainder picks +1 or -1
  function automatic logic [CW-1:0] naf(input logic [WD-1:0] b);
    logic signed [WD+1:0] v;
    logic [CW-1:0] r;
    v = {{2{b[WD-1]}}, b};
    r = '0;
    for (int i = 0; i < WD; i++) begin
      if (v[0]) begin
        if (v[1]) begin
          r[2*i+1] = 1'b1;
          v = v + 1;
        end else begin
          r[2*i] = 1'b1;
          v = v - 1;
        end
      end
      v = v >>> 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    rem     = 0;
    m_cnt   = '0;
    e_valid = 1'b0;
    e_last  = '{mode: 1'b0, fmt: 2'b0, x: '0, y: '0, u: '0, v: '0};
`ifdef BKM_DRV_SWEEP_EN
    sw_x = '0; sw_y = '0; sw_u = '0; sw_v = '0;
`endif
  endtask

  task automatic offer(input logic m, input logic [1:0] f, input logic [WD-1:0] x,
                       input logic [WD-1:0] y, input logic [WC-1:0] u, input logic [WC-1:0] v);
    bus.in_valid  = 1'b1;
    bus.in_mode   = m;
    bus.in_format = f;
    bus.in_X      = x;
    bus.in_Y      = y;
    bus.in_u      = u;
    bus.in_v      = v;
  endtask

  task automatic offer_rand();
    offer(1'($urandom), 2'($urandom), WD'({$urandom, $urandom, $urandom}),
          WD'({$urandom, $urandom, $urandom}), WC'($urandom), WC'($urandom));
  endtask

  // One clock: predict the edge from the model, then compare all outputs
  task automatic step();
    logic rdy, has, iss, use_sw;
    set_t s;
    rdy = (q.size() < DEPTH);
    chk("in_ready", bus.in_ready, rdy);
    iss = 1'b0;
    last_acc = 1'b0;
    s = e_last;
    if (srst) begin
      model_reset();
    end else begin
      has = (q.size() > 0);
      use_sw = 1'b0;
`ifdef BKM_DRV_SWEEP_EN
      use_sw = src_sel;
      if (use_sw) has = 1'b1;
`endif
      if (enable) begin
        if (rem == 0 && has) begin
          iss = 1'b1;
          rem = int'(gap);
`ifdef BKM_DRV_SWEEP_EN
          if (use_sw) begin
            s = '{mode: bus.in_mode, fmt: bus.in_format, x: sw_x, y: sw_y, u: sw_u, v: sw_v};
            sw_x++; sw_y++; sw_u++; sw_v++;
          end
`endif
          if (!use_sw) s = q.pop_front();
        end else if (rem > 0) begin
          rem--;
        end
      end
      if (bus.in_valid && rdy) begin
        q.push_back('{mode: bus.in_mode, fmt: bus.in_format, x: bus.in_X,
                      y: bus.in_Y, u: bus.in_u, v: bus.in_v});
        last_acc = 1'b1;
      end
      e_valid = iss;
      if (iss) begin
        e_last = s;
        m_cnt  = m_cnt + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid === 1'b1) strobes.push_back(cyc);
    chk("out_valid", bus.out_valid, e_valid);
    chk("out_mode", bus.out_mode, e_last.mode);
    chk("out_format", bus.out_format, e_last.fmt);
    chk("X_in_csd", bus.X_in_csd, naf(e_last.x));
    chk("Y_in_csd", bus.Y_in_csd, naf(e_last.y));
    chk("u_in_bin", bus.u_in_bin, e_last.u);
    chk("v_in_bin", bus.v_in_bin, e_last.v);
    chk("fifo_level", fifo_level, q.size());
    chk("issue_cnt", issue_cnt, m_cnt);
  endtask

  initial begin
    logic [WD-1:0] xv, yv;
    srst = 1'b1; enable = 1'b0; gap = '0; src_sel = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_format = '0;
    bus.in_X = '0; bus.in_Y = '0; bus.in_u = '0; bus.in_v = '0;
    last_acc = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    model_reset();

    // Reset: a push during srst is dropped and never issued
    offer(1'b1, 2'd1, WD'(5), WD'(0), WC'(0), WC'(0));
    step();
    srst = 1'b0;
    bus.in_valid = 1'b0;
    enable = 1'b1;
    repeat (4) step();

    // Latency 2 with fixed operands, then extreme operands
    gap = '0;
    offer(1'b1, 2'd2, WD'(3), {WD{1'b1}}, WC'(7), WC'(2));
    step();
    bus.in_valid = 1'b0;
    chk("lat_t1_valid", bus.out_valid, 1'b0);
    step();
    chk("lat_t2_valid", bus.out_valid, 1'b1);
    chk("lat_xcsd", bus.X_in_csd, naf(WD'(3)));
    chk("lat_ycsd", bus.Y_in_csd, naf({WD{1'b1}}));
    chk("lat_cnt", issue_cnt, 16'd1);
    xv = '0; xv[WD-1] = 1'b1;
    yv = {WD{1'b1}}; yv[WD-1] = 1'b0;
    offer(1'b0, 2'd3, xv, yv, {WC{1'b1}}, WC'(0));
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();

    // Back-pressure: fill while frozen, then drain back to back
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      offer_rand();
      step();
    end
    bus.in_valid = 1'b0;
    chk("bp_level", fifo_level, DEPTH);
    chk("bp_ready", bus.in_ready, 1'b0);
    offer_rand();
    step();
    strobes.delete();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (last_acc) break;
    end
    bus.in_valid = 1'b0;
    repeat (8) step();
    chk("bp_strobes", strobes.size(), 5);
    if (strobes.size() == 5) chk("bp_consec", strobes[4] - strobes[0], 4);

    // Gap cadence with a two-cycle freeze mid-gap
    enable = 1'b0;
    gap = GAP_W'(3);
    for (int i = 0; i < 3; i++) begin
      offer_rand();
      step();
    end
    bus.in_valid = 1'b0;
    strobes.delete();
    enable = 1'b1;
    repeat (6) step();
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    repeat (12) step();
    chk("gap_strobes", strobes.size(), 3);
    if (strobes.size() == 3) begin
      chk("gap_period", strobes[1] - strobes[0], 4);
      chk("gap_frozen", strobes[2] - strobes[1], 6);
    end

    // Reset in the middle of a gap with a non-empty FIFO
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer_rand();
      step();
    end
    bus.in_valid = 1'b0;
    enable = 1'b1;
    step();
    chk("mid_level", fifo_level, 3);
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("mid_flush", fifo_level, 0);
    chk("mid_cnt", issue_cnt, 16'd0);
    repeat (6) step();

    // Random traffic: random enable, gap, offers, and src_sel
    for (int c = 0; c < 300; c++) begin
      if (!bus.in_valid || last_acc) begin
        if ($urandom_range(0, 2) != 0) offer_rand();
        else bus.in_valid = 1'b0;
      end
      enable = ($urandom_range(0, 3) != 0);
      if (c % 40 == 0) gap = GAP_W'($urandom_range(0, 2));
      src_sel = 1'($urandom_range(0, 1));
      step();
    end
    bus.in_valid = 1'b0;
    src_sel = 1'b0;
    enable = 1'b1;
    repeat (20) step();

`ifdef BKM_DRV_SWEEP_EN
    // Sweep source: cadence 2 with gap=1, then run past the counter wrap
    srst = 1'b1;
    step();
    srst = 1'b0;
    src_sel = 1'b1;
    gap = GAP_W'(1);
    strobes.delete();
    repeat (10) step();
    if (strobes.size() >= 2) chk("sweep_period", strobes[1] - strobes[0], 2);
    else chk("sweep_strobes", strobes.size(), 2);
    gap = '0;
    repeat (65540) step();
    chk("sweep_wrap", issue_cnt < 16'd16, 1'b1);
    src_sel = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
